// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_responder: round-robin arbitrated single-port data memory serving |
// | per-consumer read-line / write-word requests. Optional: ALIGN_EN macro     |
// | DATA_MEM_RESPONDER_ALIGN_EN aligns read lines to READ_NUM words.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int READ_NUM      = 4,
  parameter int LATENCY       = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]          consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                    consumer_read_ready,
  output logic [NUM_CONSUMERS*READ_NUM*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                    consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]          consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]          consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                    consumer_write_ready
);

  localparam int SRCS      = 2 * NUM_CONSUMERS;
  localparam int SRC_BITS  = (SRCS > 2) ? $clog2(SRCS) : 1;
  localparam int CNT_BITS  = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int LINE_BITS = READ_NUM * DATA_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                 state;
  logic [SRC_BITS-1:0]    ptr;
  logic [SRC_BITS-1:0]    cur_src;
  logic [ADDR_BITS-1:0]   cur_addr;
  logic [DATA_BITS-1:0]   cur_wdata;
  logic [CNT_BITS-1:0]    count;
  logic [SRCS-1:0]        awaiting;
  logic [DATA_BITS-1:0]   mem [DEPTH];

  logic [SRCS-1:0]        src_valid;
  logic [SRCS-1:0]        eligible;
  logic                   grant_found;
  logic [SRC_BITS-1:0]    grant_src;
  int                     grant_cons;
  logic [ADDR_BITS-1:0]   req_addr;
  logic [DATA_BITS-1:0]   req_wdata;

  logic                   acc_fire;
  logic [SRC_BITS-1:0]    acc_src;
  int                     acc_cons;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic [DATA_BITS-1:0]   acc_wdata;
  logic [ADDR_BITS-1:0]   line_base;
  logic [LINE_BITS-1:0]   line;

  // Source 2i is consumer i's read, source 2i+1 its write.
  for (genvar c = 0; c < NUM_CONSUMERS; c++) begin : g_src
    assign src_valid[2*c]   = consumer_read_valid[c];
    assign src_valid[2*c+1] = consumer_write_valid[c];
  end

  assign eligible = src_valid & ~awaiting;

  always_comb begin
    grant_found = 1'b0;
    grant_src   = '0;
    for (int j = 0; j < SRCS; j++) begin
      if (!grant_found && eligible[(int'(ptr) + j) % SRCS]) begin
        grant_found = 1'b1;
        grant_src   = SRC_BITS'((int'(ptr) + j) % SRCS);
      end
    end
  end

  always_comb begin
    grant_cons = int'(grant_src) >> 1;
    req_addr   = grant_src[0] ? consumer_write_address[grant_cons*ADDR_BITS +: ADDR_BITS]
                              : consumer_read_address[grant_cons*ADDR_BITS +: ADDR_BITS];
    req_wdata  = consumer_write_data[grant_cons*DATA_BITS +: DATA_BITS];
  end

  // The access happens on the edge that enters RESPOND; with zero latency
  // that edge is the grant itself, so the live request is used directly.
  always_comb begin
    acc_fire  = 1'b0;
    acc_src   = cur_src;
    acc_addr  = cur_addr;
    acc_wdata = cur_wdata;
    if (state == BUSY && count == CNT_BITS'(1)) begin
      acc_fire = 1'b1;
    end else if (LATENCY == 0 && state == IDLE && grant_found) begin
      acc_fire  = 1'b1;
      acc_src   = grant_src;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_cons = int'(acc_src) >> 1;
  end

  always_comb begin
`ifdef DATA_MEM_RESPONDER_ALIGN_EN
    line_base = acc_addr & ~ADDR_BITS'(READ_NUM - 1);
`else
    line_base = acc_addr;
`endif
    line = '0;
    for (int k = 0; k < READ_NUM; k++) begin
      line[k*DATA_BITS +: DATA_BITS] = mem[line_base + ADDR_BITS'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      ptr                  <= '0;
      cur_src              <= '0;
      cur_addr             <= '0;
      cur_wdata            <= '0;
      count                <= '0;
      awaiting             <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;

      for (int i = 0; i < SRCS; i++) begin
        if (!src_valid[i]) awaiting[i] <= 1'b0;
      end

      if (acc_fire) begin
        if (acc_src[0]) begin
          mem[acc_addr]                  <= acc_wdata;
          consumer_write_ready[acc_cons] <= 1'b1;
        end else begin
          consumer_read_data[acc_cons*LINE_BITS +: LINE_BITS] <= line;
          consumer_read_ready[acc_cons]                       <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (grant_found) begin
            cur_src   <= grant_src;
            cur_addr  <= req_addr;
            cur_wdata <= req_wdata;
            ptr       <= (grant_src == SRC_BITS'(SRCS - 1)) ? '0 : grant_src + 1'b1;
            count     <= CNT_BITS'(LATENCY);
            state     <= (LATENCY == 0) ? RESPOND : BUSY;
          end
        end
        BUSY: begin
          if (count == CNT_BITS'(1)) state <= RESPOND;
          else                       count <= count - 1'b1;
        end
        RESPOND: begin
          // Block re-grant until the requester has seen its ready and let go.
          awaiting[cur_src] <= 1'b1;
          count             <= '0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_mem_responder: directed self-checking bench for data_mem_responder |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;

  localparam int A    = 8;
  localparam int D    = 8;
  localparam int N    = 4;
  localparam int R    = 4;
  localparam int L    = 2;
  localparam int LINE = R * D;

`ifdef DATA_MEM_RESPONDER_ALIGN_EN
  localparam logic [31:0] EXP_FE = 32'h0201_0000;
  localparam logic [31:0] EXP_01 = 32'h0000_0403;
  localparam logic [31:0] EXP_FF = 32'h0201_0000;
`else
  localparam logic [31:0] EXP_FE = 32'h0403_0201;
  localparam logic [31:0] EXP_01 = 32'h0000_0004;
  localparam logic [31:0] EXP_FF = 32'h0004_0302;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        consumer_read_valid;
  logic [N*A-1:0]      consumer_read_address;
  logic [N-1:0]        consumer_read_ready;
  logic [N*LINE-1:0]   consumer_read_data;
  logic [N-1:0]        consumer_write_valid;
  logic [N*A-1:0]      consumer_write_address;
  logic [N*D-1:0]      consumer_write_data;
  logic [N-1:0]        consumer_write_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N), .READ_NUM(R), .LATENCY(L)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .consumer_write_valid  (consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data   (consumer_write_data),
    .consumer_write_ready  (consumer_write_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE-1:0] line_of(input int c);
    return consumer_read_data[c*LINE +: LINE];
  endfunction

  task automatic wait_ready(input int c, input bit is_wr, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((is_wr ? consumer_write_ready[c] : consumer_read_ready[c]) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_write(input int c, input logic [A-1:0] addr, input logic [D-1:0] data,
                          input string tag);
    int lat;
    consumer_write_address[c*A +: A] = addr;
    consumer_write_data[c*D +: D]    = data;
    consumer_write_valid[c]          = 1'b1;
    wait_ready(c, 1'b1, lat);
    check({tag, "_lat"}, lat, L + 1);
    consumer_write_valid[c] = 1'b0;
    tick();
    check({tag, "_pulse"}, consumer_write_ready[c], 1'b0);
    tick();
  endtask

  task automatic do_read(input int c, input logic [A-1:0] addr, input string tag,
                         output logic [LINE-1:0] data);
    int lat;
    consumer_read_address[c*A +: A] = addr;
    consumer_read_valid[c]          = 1'b1;
    wait_ready(c, 1'b0, lat);
    check({tag, "_lat"}, lat, L + 1);
    data = line_of(c);
    consumer_read_valid[c] = 1'b0;
    tick();
    check({tag, "_pulse"}, consumer_read_ready[c], 1'b0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LINE-1:0] line;
    int first [N];
    int pulses [N];
    int lat, p1, r2, seen;

    reset                  = 1'b1;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    repeat (3) tick();
    check("rst_rd_ready", consumer_read_ready, '0);
    check("rst_wr_ready", consumer_write_ready, '0);
    check("rst_rd_data", |consumer_read_data, 1'b0);
    reset = 1'b0;
    tick();

    // Write then read-back through the same consumer.
    do_write(0, 8'h10, 8'hA5, "wr10");
    do_read(0, 8'h10, "rd10", line);
    check("rd10_line", line, 32'h0000_00A5);
    repeat (3) tick();
    check("rd10_hold", line_of(0), 32'h0000_00A5);

    // Write valid dropped right after grant is still served.
    consumer_write_address[2*A +: A] = 8'h30;
    consumer_write_data[2*D +: D]    = 8'h5C;
    consumer_write_valid[2]          = 1'b1;
    tick();
    consumer_write_valid[2] = 1'b0;
    wait_ready(2, 1'b1, lat);
    check("wrdrop_lat", lat + 1, L + 1);
    tick();
    tick();
    do_read(2, 8'h30, "rd30", line);
    check("rd30_line", line, 32'h0000_005C);
    check("rd10_other", line_of(0), 32'h0000_00A5);

    // Four simultaneous reads from pointer 0.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst2_data", |consumer_read_data, 1'b0);
    for (int c = 0; c < N; c++) begin
      first[c]  = -1;
      pulses[c] = 0;
      consumer_read_address[c*A +: A] = 8'(8'h40 + c);
    end
    consumer_read_valid = '1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      for (int c = 0; c < N; c++) begin
        if (consumer_read_ready[c] === 1'b1) begin
          if (first[c] < 0) first[c] = cyc;
          pulses[c]++;
          consumer_read_valid[c] = 1'b0;
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      check($sformatf("rr_time%0d", c), first[c], (L + 1) + c * (L + 2));
      check($sformatf("rr_once%0d", c), pulses[c], 1);
    end

    // Line assembly across the top of the address space.
    do_write(0, 8'hFE, 8'h01, "wrFE");
    do_write(0, 8'hFF, 8'h02, "wrFF");
    do_write(0, 8'h00, 8'h03, "wr00");
    do_write(0, 8'h01, 8'h04, "wr01");
    do_read(2, 8'hFE, "rdFE", line);
    check("rdFE_line", line, EXP_FE);
    do_read(1, 8'h01, "rd01", line);
    check("rd01_line", line, EXP_01);

    // Consumer 1 holds valid past its ready; consumer 2 is served meanwhile.
    consumer_read_address[1*A +: A] = 8'hFF;
    consumer_read_valid[1]          = 1'b1;
    wait_ready(1, 1'b0, lat);
    check("hold_lat", lat, L + 1);
    check("hold_line", line_of(1), EXP_FF);
    p1 = 1;
    r2 = 0;
    consumer_read_address[2*A +: A] = 8'h00;
    consumer_read_valid[2]          = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (consumer_read_ready[1] === 1'b1) p1++;
      if (consumer_read_ready[2] === 1'b1) begin
        r2++;
        consumer_read_valid[2] = 1'b0;
      end
    end
    consumer_read_valid[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (consumer_read_ready[1] === 1'b1) p1++;
      if (consumer_read_ready[2] === 1'b1) r2++;
    end
    check("hold_once", p1, 1);
    check("hold_other", r2, 1);
    check("hold_other_line", line_of(2), 32'h0000_0403);
    check("hold_keep", line_of(1), EXP_FF);
    do_read(1, 8'h01, "rerd01", line);
    check("rerd01_line", line, EXP_01);

    // Reset during BUSY cancels the write and its ready.
    consumer_write_address[3*A +: A] = 8'h20;
    consumer_write_data[3*D +: D]    = 8'h77;
    consumer_write_valid[3]          = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    seen  = 0;
    tick();
    if (consumer_write_ready[3] === 1'b1) seen++;
    tick();
    if (consumer_write_ready[3] === 1'b1) seen++;
    reset = 1'b0;
    consumer_write_valid[3] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (consumer_write_ready[3] === 1'b1) seen++;
    end
    check("abort_noready", seen, 0);
    check("abort_data", |consumer_read_data, 1'b0);
    do_read(3, 8'h20, "rd20", line);
    check("rd20_line", line, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
